row_enc: RTL and testbench

- Inverse of the crossbar row decoder: accepts a PAIR_ROW_NO-bit row-activity vector (multi-hot) and serialises it into a stream of binary row indices, one per handshake.
- Each index is wide enough to drive the decoder's row_sel input.
- Sits between the spike/activity source and the row decoder, so the array is driven one pair-row at a time.

---
 rtl/row_enc.sv | 59 +++++
 tb/tb_row_enc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/row_enc.sv
// row_enc: serialise a multi-hot row-activity vector into a stream of binary row indices.
//   clk, rst (async, active-high)
//   in_valid/in_ready/row_vec           : vector input handshake
//   out_valid/out_ready/row_idx/out_last : index output handshake, out_last marks the final index
//   empty                                : one-cycle pulse after accepting an all-zero vector
//   Macro ROW_ENC_HIGH_FIRST_EN: emit highest set bit first (descending order).
module row_enc #(
  parameter int PAIR_ROW_NO = 2**6,
  localparam int W = $clog2(PAIR_ROW_NO)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAIR_ROW_NO-1:0] row_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           row_idx,
  output logic                   out_last,
  output logic                   empty
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [PAIR_ROW_NO-1:0] pending;
  logic [W-1:0] idx;
  logic single, fire_in, fire_out;
  always_comb begin
    idx = '0;
`ifdef ROW_ENC_HIGH_FIRST_EN
    for (int i = 0; i < PAIR_ROW_NO; i++) if (pending[i]) idx = W'(i);
`else
    for (int i = PAIR_ROW_NO - 1; i >= 0; i--) if (pending[i]) idx = W'(i);
`endif
  end
  // clearing the lowest set bit leaves zero only when exactly one bit was set
  assign single = |pending & ~|(pending & (pending - PAIR_ROW_NO'(1)));
  assign fire_in = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((fire_in && |row_vec) ? EMIT : IDLE)
                              : ((fire_out && out_last) ? IDLE : EMIT);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == EMIT;
    row_idx = out_valid ? idx : '0;
    out_last = out_valid & single;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      empty <= 1'b0;
    end else begin
      pending <= fire_in ? row_vec : fire_out ? pending & ~(PAIR_ROW_NO'(1) << idx) : pending;
      empty <= fire_in & ~|row_vec;
    end
endmodule

// File: tb/tb_row_enc.sv
// tb_row_enc: directed checks of row_enc at PAIR_ROW_NO=64 (honours ROW_ENC_HIGH_FIRST_EN).
module tb_row_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [63:0] row_vec = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [5:0] row_idx;
  logic out_last;
  logic empty;
  int vectors = 0;
  int miscompares = 0;
  int lasts;
  int e;
  logic [5:0] exp_a [3];

  row_enc #(.PAIR_ROW_NO(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .row_vec(row_vec),
    .out_valid(out_valid), .out_ready(out_ready), .row_idx(row_idx), .out_last(out_last),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] v);
    in_valid = 1'b1;
    row_vec = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
`ifdef ROW_ENC_HIGH_FIRST_EN
    exp_a[0] = 6'd63; exp_a[1] = 6'd2; exp_a[2] = 6'd0;
`else
    exp_a[0] = 6'd0; exp_a[1] = 6'd2; exp_a[2] = 6'd63;
`endif
    repeat (2) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_empty", empty, 0);
    rst = 1'b0;
    step();
    // sparse vector, free-running consumer
    accept(64'h8000_0000_0000_0005);
    for (int i = 0; i < 3; i++) begin
      chk("a_valid", out_valid, 1);
      chk("a_in_ready", in_ready, 0);
      chk("a_idx", row_idx, exp_a[i]);
      chk("a_last", out_last, i == 2);
      step();
    end
    chk("a_done_valid", out_valid, 0);
    chk("a_done_in_ready", in_ready, 1);
    // same vector with a 3-cycle stall on the second beat; in_valid during EMIT must be ignored
    accept(64'h8000_0000_0000_0005);
    chk("s_idx0", row_idx, exp_a[0]);
    step();
    chk("s_idx1", row_idx, exp_a[1]);
    out_ready = 1'b0;
    in_valid = 1'b1;
    row_vec = 64'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_hold_valid", out_valid, 1);
      chk("s_hold_idx", row_idx, exp_a[1]);
      chk("s_hold_last", out_last, 0);
      chk("s_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    row_vec = '0;
    step();
    chk("s_idx2", row_idx, exp_a[2]);
    chk("s_last", out_last, 1);
    step();
    chk("s_done_valid", out_valid, 0);
    step();
    chk("s_ignored_valid", out_valid, 0);
    // all-zero vector
    accept(64'h0);
    chk("z_empty", empty, 1);
    chk("z_valid", out_valid, 0);
    chk("z_in_ready", in_ready, 1);
    step();
    chk("z_empty_off", empty, 0);
    chk("z_valid2", out_valid, 0);
    // all-ones vector
    accept('1);
    lasts = 0;
    for (int i = 0; i < 64; i++) begin
`ifdef ROW_ENC_HIGH_FIRST_EN
      e = 63 - i;
`else
      e = i;
`endif
      chk("f_valid", out_valid, 1);
      chk("f_idx", row_idx, 64'(e));
      chk("f_last", out_last, i == 63);
      if (out_last) lasts++;
      step();
    end
    chk("f_last_count", 64'(lasts), 1);
    chk("f_done_valid", out_valid, 0);
    // reset asynchronously mid-burst
    accept('1);
    repeat (10) step();
`ifdef ROW_ENC_HIGH_FIRST_EN
    chk("r_idx10", row_idx, 53);
`else
    chk("r_idx10", row_idx, 10);
`endif
    #3 rst = 1'b1;
    #1;
    chk("r_async_valid", out_valid, 0);
    chk("r_async_in_ready", in_ready, 1);
    chk("r_async_idx", row_idx, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r_no_beats", out_valid, 0);
    end
    // single top bit
    accept(64'h8000_0000_0000_0000);
    chk("t_idx", row_idx, 63);
    chk("t_last", out_last, 1);
    step();
    chk("t_done", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
